// File: rtl/i2s_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2s_pkg - shared state type and frame geometry for the I2S playback block. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package i2s_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME0 = 3'd1,
        PRIME1 = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    localparam int WORDS          = 32;
    localparam int HALF_WORDS     = 16;
    localparam int BITS_PER_WORD  = 16;
    localparam int SCLK_PER_FRAME = 32;

endpackage
`default_nettype wire

// File: rtl/i2s_clkgen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2s_clkgen - sclk divider and ws generator with fall / end-of-frame strobes|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic drain,
    output logic sclk,
    output logic ws,
    output logic sclk_fall,
    output logic frame_end
);

    localparam int FW = $clog2(SCLK_PER_FRAME);
    localparam int WW = $clog2(BITS_PER_WORD);

    logic [7:0]    div_cnt;
    logic [FW-1:0] frame_cnt;
    logic          started;
    logic          div_wrap;

    assign div_wrap  = en && (div_cnt == 8'(CLK_DIV - 1));
    assign sclk_fall = div_wrap && sclk;
    // The very first fall raises ws but does not close a frame.
    assign frame_end = sclk_fall && started && (frame_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            frame_cnt <= '0;
            started   <= 1'b0;
            sclk      <= 1'b0;
            ws        <= 1'b0;
        end else if (!en) begin
            div_cnt   <= '0;
            frame_cnt <= '0;
            started   <= 1'b0;
            sclk      <= 1'b0;
            ws        <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
            if (div_wrap)
                sclk <= ~sclk;
            if (sclk_fall) begin
                started   <= 1'b1;
                frame_cnt <= frame_cnt + FW'(1);
                if (frame_cnt[WW-1:0] == '0)
                    ws <= (drain && frame_end) ? 1'b0 : ~ws;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_play_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2s_play_ctrl - I2S playback FSM with double-buffer refill handshake.      |
// | Optional underrun/timeout logic: `define I2S_PLAY_CTRL_UNDERRUN_EN. Rev 1.0|
// +----------------------------------------------------------------------------+
module i2s_play_ctrl
    import i2s_pkg::*;
#(
    parameter int CLK_DIV             = 8,
    parameter int FILL_TIMEOUT_EN_CYC = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic [4:0] play_addr,
    output logic       sclk,
    output logic       ws,
    output logic       fill_req,
    output logic       fill_half,
    input  logic       fill_ack,
    output logic       busy,
    output logic       underrun,
    input  logic       underrun_clr
);

    state_t state, state_nxt;
    logic   fill_req_nxt, fill_half_nxt;
    logic   drain_done, drain_done_nxt;
    logic   addr_msb_q;
    logic   half_cross;
    logic   clk_en, sclk_fall, frame_end, drain_end;
    logic   ur_set;
    logic   timeout;
    logic   unused_addr;

    assign unused_addr = ^play_addr[3:0];
    assign half_cross  = (state == RUN) && (play_addr[4] != addr_msb_q);
    assign clk_en      = (state == RUN) || ((state == DRAIN) && !drain_done);
    assign drain_end   = sclk_fall && frame_end;
    assign busy        = (state != IDLE);

    i2s_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (clk_en),
        .drain     (state == DRAIN),
        .sclk      (sclk),
        .ws        (ws),
        .sclk_fall (sclk_fall),
        .frame_end (frame_end)
    );

`ifdef I2S_PLAY_CTRL_UNDERRUN_EN
    localparam int TW = (FILL_TIMEOUT_EN_CYC > 1) ? $clog2(FILL_TIMEOUT_EN_CYC) : 1;

    logic [TW-1:0] to_cnt;
    logic          priming;

    assign priming = (state == PRIME0) || (state == PRIME1);
    assign timeout = (FILL_TIMEOUT_EN_CYC != 0) && priming && fill_req && !fill_ack
                   && (32'(to_cnt) == 32'(FILL_TIMEOUT_EN_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            to_cnt <= '0;
        else if (priming && fill_req && !fill_ack)
            to_cnt <= to_cnt + TW'(1);
        else
            to_cnt <= '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            underrun <= 1'b0;
        else if (ur_set)
            underrun <= 1'b1;
        else if (underrun_clr)
            underrun <= 1'b0;
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign underrun   = 1'b0;
    assign unused_cfg = underrun_clr ^ ur_set ^ (FILL_TIMEOUT_EN_CYC != 0);
`endif

    always_comb begin
        state_nxt      = state;
        fill_req_nxt   = fill_req;
        fill_half_nxt  = fill_half;
        drain_done_nxt = 1'b0;
        ur_set         = 1'b0;
        if (fill_req && fill_ack)
            fill_req_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = PRIME0;
            end
            PRIME0, PRIME1: begin
                if (stop) begin
                    state_nxt    = IDLE;
                    fill_req_nxt = 1'b0;
                end else if (fill_req && fill_ack) begin
                    state_nxt = (state == PRIME0) ? PRIME1 : RUN;
                end else if (timeout) begin
                    state_nxt    = IDLE;
                    fill_req_nxt = 1'b0;
                    ur_set       = 1'b1;
                end else if (!fill_req) begin
                    fill_req_nxt  = 1'b1;
                    fill_half_nxt = (state == PRIME1);
                end
            end
            RUN: begin
                if (stop)
                    state_nxt = DRAIN;
                // A crossing that finds the previous refill still open is a miss.
                if (half_cross) begin
                    if (fill_req && !fill_ack) begin
                        ur_set = 1'b1;
                    end else begin
                        fill_req_nxt  = 1'b1;
                        fill_half_nxt = ~play_addr[4];
                    end
                end
            end
            DRAIN: begin
                drain_done_nxt = drain_done || drain_end;
                if (drain_done_nxt && !fill_req) begin
                    state_nxt      = IDLE;
                    drain_done_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            fill_req   <= 1'b0;
            fill_half  <= 1'b0;
            drain_done <= 1'b0;
            addr_msb_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            fill_req   <= fill_req_nxt;
            fill_half  <= fill_half_nxt;
            drain_done <= drain_done_nxt;
            addr_msb_q <= play_addr[4];
        end
    end

endmodule
`default_nettype wire

// File: doc/i2s_play_ctrl.md
I2S_PLAY_CTRL -- requirements
Module: i2s_play_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 8, is the number of clk cycles per sclk half-period; the legal range is 4..255.
REQ-002 Parameter FILL_TIMEOUT_EN_CYC, default 0, means "no prime timeout" when 0; otherwise it is the maximum number of clk cycles to wait for fill_ack while priming.
REQ-003 clk  in  1  system clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle pulse that begins playback.
REQ-006 stop  in  1  single-cycle pulse that ends playback at the next frame boundary.
REQ-007 play_addr  in  5  word address currently presented by the I2S player (clk domain).
REQ-008 sclk  out  1  generated I2S bit clock.
REQ-009 ws  out  1  generated I2S word select.
REQ-010 fill_req  out  1  request to load one 16-word half of the sample buffer.
REQ-011 fill_half  out  1  half to load: 0 = words 0-15, 1 = words 16-31.
REQ-012 fill_ack  in  1  single-cycle pulse meaning the requested half has been written.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 underrun  out  1  sticky refill-miss flag.
REQ-015 underrun_clr  in  1  single-cycle pulse that clears underrun.

Function
REQ-016 The FSM states SHALL be IDLE, PRIME0, PRIME1, RUN and DRAIN.
REQ-017 IDLE->PRIME0 on start; start is ignored in every other state.
REQ-018 PRIME0: assert fill_req with fill_half=0; on fill_ack go to PRIME1.
REQ-019 PRIME1: assert fill_req with fill_half=1; on fill_ack go to RUN.
REQ-020 Prime timeout (FILL_TIMEOUT_EN_CYC>0 only): if fill_ack does not arrive within the timeout in PRIME0 or PRIME1, drop fill_req, set underrun and return to IDLE.
REQ-021 fill_req SHALL stay high and fill_half SHALL stay stable until the cycle fill_ack is sampled; fill_req falls on the next clk edge.
REQ-022 fill_ack received while fill_req is low SHALL be ignored.
REQ-023 sclk and ws are held at 0 in IDLE, PRIME0 and PRIME1.
REQ-024 RUN: sclk toggles every CLK_DIV clk cycles, starting low; the first rising edge comes CLK_DIV cycles after RUN entry.
REQ-025 ws changes only on sclk falling edges: it goes high at the first falling edge, then alternates between 16 sclk periods high and 16 sclk periods low; one frame is 32 sclk periods.
REQ-026 In RUN, a play_addr[4] transition 0->1 requests half 0, and a transition 1->0 requests half 1; detection uses the registered previous value of play_addr[4].
REQ-027 If a new half request arises while fill_req is still pending: set underrun; keep the pending request unchanged; drop the new request.
REQ-028 stop in RUN -> DRAIN; stop in PRIME0 or PRIME1 -> IDLE immediately with fill_req dropped; stop in IDLE is ignored.
REQ-029 DRAIN: sclk and ws continue until the end of the current ws-low phase (the sclk falling edge where ws would next rise); then go to IDLE with sclk=0 and ws=0.
REQ-030 A pending refill request in DRAIN stays asserted until fill_ack; IDLE is entered only after fill_req is low.
REQ-031 underrun_clr clears underrun; if clear and set occur in the same cycle, set wins.
REQ-032 start and stop in the same cycle in IDLE: start wins; in RUN: stop wins.

Reset
REQ-033 While reset_n is low: state=IDLE, sclk=0, ws=0, fill_req=0, fill_half=0, busy=0, underrun=0, and all counters=0.
REQ-034 Reset mid-frame abandons the frame immediately; there is no drain.

Configuration
REQ-035 I2S_PLAY_CTRL_UNDERRUN_EN defined: REQ-020, REQ-027 and REQ-031 are implemented as written.
REQ-036 I2S_PLAY_CTRL_UNDERRUN_EN undefined: underrun is tied to 0, underrun_clr is ignored, and the prime timeout logic is removed (priming waits forever); all other behaviour is identical.

Structure
REQ-037 Shared package i2s_pkg holds: the state enum typedef; WORDS=32; HALF_WORDS=16; BITS_PER_WORD=16; SCLK_PER_FRAME=32.
REQ-038 Sub-module i2s_clkgen holds the CLK_DIV divider, sclk, ws, the sclk falling-edge strobe and the end-of-frame strobe; the FSM and fill handshake stay in i2s_play_ctrl.

Verification
REQ-039 Bench scenario, prime sequence: reset, start, ack each request after 5 cycles -> fill_half=0 then fill_half=1; RUN is entered; sclk first rises CLK_DIV cycles after RUN entry.
REQ-040 Bench scenario, clock shape: CLK_DIV=8 -> sclk period 16 clk; ws high for 256 clk and low for 256 clk; ws edges coincide with sclk falling edges.
REQ-041 Bench scenario, refill: play_addr steps 15->16 -> fill_req with fill_half=0; play_addr steps 31->0 -> fill_req with fill_half=1.
REQ-042 Bench scenario, underrun: withhold fill_ack across two half crossings -> underrun=1 on the second crossing and fill_half unchanged; underrun_clr -> underrun=0.
REQ-043 Bench scenario, stop and drain: stop mid ws-high -> DRAIN; the frame completes, then sclk=0, ws=0, busy=0; a second start re-primes from half 0.
REQ-044 Bench scenario, reset in RUN: reset_n low mid-frame -> all outputs are 0 within the same cycle.
